// File: rtl/ksa_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone adder/subtractor.
interface ksa_pipe_addsub_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    // Operand source / result sink side.
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );

    // Arithmetic block side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/ksa_pipe_addsub.sv
// Parametrised Kogge-Stone adder/subtractor with optional per-level pipelining,
// status flags, tag passthrough and a global-stall valid/ready handshake.
module ksa_pipe_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PIPE  = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    ksa_pipe_addsub_if.slave bus
);
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned IDX_W  = LEVELS;
    localparam int unsigned LV_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    // One prefix-tree stage: running G/P plus everything the sum stage needs.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             sign_a;
        logic             sign_b;
        logic             cin;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pp;
    } lvl_t;

    // One Kogge-Stone level of span d; bits below d pass through.
    function automatic lvl_t prefix_step(input lvl_t x, input int unsigned d);
        lvl_t y;
        y = x;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i >= d) begin
                y.g[IDX_W'(i)]  = x.g[IDX_W'(i)] | (x.pp[IDX_W'(i)] & x.g[IDX_W'(i - d)]);
                y.pp[IDX_W'(i)] = x.pp[IDX_W'(i)] & x.pp[IDX_W'(i - d)];
            end
        end
        return y;
    endfunction

    logic             advance_c;
    logic [WIDTH-1:0] b_eff_c;
    logic             cin_eff_c;
    lvl_t             st0_q;
    lvl_t             lvl0_c;
    lvl_t             fin_c;
    logic [WIDTH-1:0] sum_c;
    logic             unused_pp;

    // Global stall: every stage moves together when the output can drain.
    assign advance_c    = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = wb_rst_ni & advance_c;

    // Subtract is A + ~B + ~cin.
    always_comb begin
        b_eff_c   = bus.in_b ^ {WIDTH{bus.in_sub}};
        cin_eff_c = bus.in_cin ^ bus.in_sub;
    end

    // Input register: generate/propagate, carry-in, signs and tag.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            st0_q <= '0;
        end else if (advance_c) begin
            st0_q.valid  <= bus.in_valid;
            st0_q.tag    <= bus.in_tag;
            st0_q.sign_a <= bus.in_a[WIDTH-1];
            st0_q.sign_b <= b_eff_c[WIDTH-1];
            st0_q.cin    <= cin_eff_c;
            st0_q.p      <= bus.in_a ^ b_eff_c;
            st0_q.g      <= bus.in_a & b_eff_c;
            st0_q.pp     <= bus.in_a ^ b_eff_c;
        end
    end

    // Carry-in folded in as G[-1] so the tree needs no extra column.
    always_comb begin
        lvl0_c      = st0_q;
        lvl0_c.g[0] = st0_q.g[0] | (st0_q.p[0] & st0_q.cin);
    end

    if (PIPE != 0) begin : g_pipe
        lvl_t lvl_q [LEVELS];

        // Registered prefix levels advancing in lockstep with the valid bit.
        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                for (int k = 0; k < LEVELS; k++) lvl_q[LV_W'(k)] <= '0;
            end else if (advance_c) begin
                lvl_q[0] <= prefix_step(lvl0_c, 32'd1);
                for (int k = 1; k < LEVELS; k++) begin
                    lvl_q[LV_W'(k)] <= prefix_step(lvl_q[LV_W'(k - 1)], 32'd1 << k);
                end
            end
        end

        assign fin_c = lvl_q[LEVELS-1];
    end else begin : g_comb
        // Whole prefix tree in one combinational cloud.
        always_comb begin
            fin_c = lvl0_c;
            for (int k = 0; k < LEVELS; k++) fin_c = prefix_step(fin_c, 32'd1 << k);
        end
    end

    // Group propagate of the final level has no consumer.
    assign unused_pp = ^fin_c.pp;

    // Sum bit i takes the carry into it, i.e. the prefix generate of bit i-1.
    always_comb begin
        sum_c = fin_c.p ^ {fin_c.g[WIDTH-2:0], fin_c.cin};
    end

    // Output register with flags; holds while the sink stalls.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_zero  <= 1'b0;
            bus.out_tag   <= '0;
        end else if (advance_c) begin
            bus.out_valid <= fin_c.valid;
            bus.out_sum   <= sum_c;
            bus.out_cout  <= fin_c.g[WIDTH-1];
            bus.out_ovf   <= (fin_c.sign_a == fin_c.sign_b) & (sum_c[WIDTH-1] != fin_c.sign_a);
            bus.out_zero  <= ~|sum_c;
            bus.out_tag   <= fin_c.tag;
        end
    end
endmodule

// File: doc/ksa_pipe_addsub.md
Name: ksa_pipe_addsub

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor. Successor to the fixed 16-bit combinational KSA used on the user-area IO pads.
- Adds generic power-of-two width, optional per-prefix-level pipelining, a subtract mode, carry/borrow-in, status flags, a tag passthrough and a valid/ready handshake.
- Sits between a Wishbone/LA-driven operand source and a result sink inside user_proj.

Parameters:
- WIDTH, 32, operand width; power of two, >= 4. LEVELS = log2(WIDTH) prefix levels.
- PIPE, 1, 1 = register after every prefix level; 0 = prefix tree is combinational.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- wb_clk_i  in  1  clock; all state updates on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add) / borrow-in (sub).
- in_sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry-out. For sub: 1 = no borrow.
- out_ovf  out  1  signed two's-complement overflow.
- out_zero  out  1  out_sum == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset: while wb_rst_ni is low, all pipeline valid bits and all outputs are 0, asynchronously. Release is synchronous in effect: the first accept can occur on the first rising edge after wb_rst_ni goes high.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- Operand conditioning:
  - Effective B is B xor {WIDTH{in_sub}}.
  - Effective carry-in is in_cin xor in_sub, so sub computes A + ~B + ~cin = A - B - cin.
- Stage 0 (input register): latches g = A & Beff, p = A ^ Beff, carry-in, sub, tag, and the sign bits of A and Beff.
- Prefix levels k = 0..LEVELS-1, span d = 2^k:
  - for i >= d: G[i] = G[i] | (P[i] & G[i-d]) and P[i] = P[i] & P[i-d];
  - for i < d: G and P pass through.
  - Carry-in is folded in as G[-1] = cin, i.e. G[0] = g[0] | (p[0] & cin) before level 0.
  - With PIPE=1, each level's outputs are registered together with the valid bit, tag, p vector and sign bits.
- Final stage (output register):
  - sum[0] = p[0] ^ cin; sum[i] = p[i] ^ G[i-1].
  - cout = G[WIDTH-1].
  - ovf = (signA == signBeff) & (sum[WIDTH-1] != signA).
  - zero = ~|sum.
- Latency from accept to out_valid: 2 + LEVELS cycles when PIPE=1; 2 cycles when PIPE=0. Example: WIDTH=32, PIPE=1 gives 7.
- Flow control: global stall.
  - advance = out_ready | ~out_valid; in_ready = advance.
  - When advance = 0, every stage register (data and valid) holds.
  - A beat is accepted iff in_valid & in_ready.
  - Bubbles (valid = 0) advance like data and are not compressed.
- out_* are stable while out_valid & ~out_ready.
- in_valid with in_ready low: the beat is not captured. The source must hold it.
- Simultaneous accept and emit in the same cycle is legal, giving full throughput of one result per cycle.
- Results emerge strictly in acceptance order. No beat is dropped or duplicated.
- Width rules: all arithmetic is modulo 2^WIDTH. There is no internal width growth beyond the prefix G/P vectors.
- The combinational in_ready path (out_ready -> in_ready) is permitted and documented.

Test Plan:
- WIDTH=32, PIPE=1: add 0xFFFF_FFFF + 0x0000_0001, cin=0 -> after 7 cycles: sum=0x0000_0000, cout=1, zero=1, ovf=0.
- Sub 0x8000_0000 - 0x0000_0001, cin=0 -> sum=0x7FFF_FFFF, cout=1, ovf=1, zero=0. Sub 3 - 5 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Carry/borrow-in: add 5 + 3, cin=1 -> 9. Sub 5 - 3, cin=1 -> 1. Each result carries its tag (0xA, 0x5) unchanged.
- Stream 200 random beats with tag = sequence number, with in_valid and out_ready each randomly 50%. Every result must match the scoreboard (A±B∓cin, flags), in order, with no drop or duplicate. Outputs must hold steady during stalls.
- Assert wb_rst_ni low for 1 cycle with 5 beats in flight -> out_valid=0 immediately. No stale results after release. The next accepted beat returns after exactly 7 cycles.
- WIDTH=8, PIPE=0: 0x7F + 0x01 -> 0x80, ovf=1, cout=0, latency 2. Back-to-back beats with out_ready=1 -> one result per cycle.
